// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes alu_op/funct3/funct7 to a control code, computes single-cycle
// ops into an output register, and runs MUL on an iterative shift-add multiplier.
module alu_exec_unit #(
  parameter int XLEN    = 64,
  parameter int MUL_EN  = 1,
  parameter int MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  localparam int SHW   = $clog2(XLEN);
  localparam int STEPS = XLEN / MUL_BPC;
  localparam int CW    = $clog2(STEPS) + 1;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SRA  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
  localparam logic [3:0] C_MUL  = 4'b1010;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  function automatic logic [3:0] f3_map(input logic [2:0] f3);
    logic [3:0] c;
    case (f3)
      3'b000:  c = C_ADD;
      3'b001:  c = C_SLL;
      3'b010:  c = C_SLT;
      3'b011:  c = C_SLTU;
      3'b100:  c = C_XOR;
      3'b101:  c = C_SRL;
      3'b110:  c = C_OR;
      3'b111:  c = C_AND;
      default: c = C_ADD;
    endcase
    return c;
  endfunction

  // Returns {illegal, ctrl}; undefined encodings fall back to ADD with illegal set.
  function automatic logic [4:0] decode(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [4:0] d;
    case (op)
      2'b00: d = {1'b0, C_ADD};
      2'b01: d = {1'b0, C_SUB};
      2'b10: begin
        if (f7 == 7'b0000000)                                 d = {1'b0, f3_map(f3)};
        else if (f7 == 7'b0100000 && f3 == 3'b000)            d = {1'b0, C_SUB};
        else if (f7 == 7'b0100000 && f3 == 3'b101)            d = {1'b0, C_SRA};
        else if (f7 == 7'b0000001 && f3 == 3'b000 && MUL_EN != 0) d = {1'b0, C_MUL};
        else                                                  d = {1'b1, C_ADD};
      end
      2'b11: begin
        if (f3 == 3'b101 && f7[5]) d = {1'b0, C_SRA};
        else                       d = {1'b0, f3_map(f3)};
      end
      default: d = {1'b1, C_ADD};
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] compute(input logic [3:0] c, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [SHW-1:0]  sh;
    sh = b[SHW-1:0];
    case (c)
      C_AND:   r = a & b;
      C_OR:    r = a | b;
      C_ADD:   r = a + b;
      C_XOR:   r = a ^ b;
      C_SLL:   r = a << sh;
      C_SRL:   r = a >> sh;
      C_SUB:   r = a - b;
      C_SLT:   r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SRA:   r = $unsigned($signed(a) >>> sh);
      C_SLTU:  r = {{(XLEN-1){1'b0}}, (a < b)};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  state_t          state_r;
  logic            out_valid_r, zero_r, illegal_r;
  logic [XLEN-1:0] result_r, mul_a_r, mul_b_r, mul_acc_r;
  logic [3:0]      alu_ctrl_r;
  logic [CW-1:0]   count_r;

  logic            in_ready_s, accept_s, illegal_s;
  logic [3:0]      ctrl_s;
  logic [4:0]      dec_s;
  logic [XLEN-1:0] single_s, step_acc_s;

  // Handshake and decode of the presented operation.
  always_comb begin
    if (state_r == S_IDLE) in_ready_s = !out_valid_r || out_ready;
    else                   in_ready_s = 1'b0;
    accept_s  = in_valid && in_ready_s;
    dec_s     = decode(alu_op, funct3, funct7);
    illegal_s = dec_s[4];
    ctrl_s    = dec_s[3:0];
    if (illegal_s) single_s = {XLEN{1'b0}};
    else           single_s = compute(ctrl_s, op_a, op_b);
  end

  // One multiplier step: add the shifted multiplicand for each retired multiplier bit.
  always_comb begin
    step_acc_s = mul_acc_r;
    for (int i = 0; i < MUL_BPC; i++) begin
      if (mul_b_r[i]) step_acc_s = step_acc_s + (mul_a_r << i);
      else            step_acc_s = step_acc_s;
    end
  end

  // Control FSM, output register and multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b0;
      alu_ctrl_r  <= 4'b0000;
      illegal_r   <= 1'b0;
      mul_a_r     <= {XLEN{1'b0}};
      mul_b_r     <= {XLEN{1'b0}};
      mul_acc_r   <= {XLEN{1'b0}};
      count_r     <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s && ctrl_s == C_MUL) begin
            // Output register is free or draining this cycle, so it is empty during MUL.
            mul_a_r     <= op_a;
            mul_b_r     <= op_b;
            mul_acc_r   <= {XLEN{1'b0}};
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            state_r     <= S_MUL;
          end else if (accept_s) begin
            result_r    <= single_s;
            zero_r      <= (single_s == {XLEN{1'b0}});
            alu_ctrl_r  <= ctrl_s;
            illegal_r   <= illegal_s;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        S_MUL: begin
          mul_acc_r <= step_acc_s;
          mul_a_r   <= mul_a_r << MUL_BPC;
          mul_b_r   <= mul_b_r >> MUL_BPC;
          count_r   <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == CW'(STEPS - 1)) begin
            result_r    <= step_acc_s;
            zero_r      <= (step_acc_s == {XLEN{1'b0}});
            alu_ctrl_r  <= C_MUL;
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_MUL;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign alu_ctrl  = alu_ctrl_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=64, MUL_EN=1, MUL_BPC=1): directed cases
// followed by random operations compared against a name-based behavioural model.
module tb_alu_exec_unit;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] op_a, op_b, result;
  logic [3:0]  alu_ctrl;

  int checks = 0;
  int errors = 0;

  logic [1:0]  r_op;
  logic [2:0]  r_f3;
  logic [6:0]  r_f7;
  logic [63:0] r_a, r_b;
  int          sel;
  logic        stale;

  string f3_names [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};

  alu_exec_unit #(.XLEN(64), .MUL_EN(1), .MUL_BPC(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .alu_ctrl(alu_ctrl), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] code_of(input string nm);
    if (nm == "AND")  return 4'd0;
    if (nm == "OR")   return 4'd1;
    if (nm == "XOR")  return 4'd3;
    if (nm == "SLL")  return 4'd4;
    if (nm == "SRL")  return 4'd5;
    if (nm == "SUB")  return 4'd6;
    if (nm == "SLT")  return 4'd7;
    if (nm == "SRA")  return 4'd8;
    if (nm == "SLTU") return 4'd9;
    if (nm == "MUL")  return 4'd10;
    return 4'd2;
  endfunction

  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [63:0] a, input logic [63:0] b, output logic ill,
                                output logic [3:0] ctrl, output logic [63:0] res);
    string nm;
    int    sh;
    nm = "ILL";
    sh = int'(b[5:0]);
    if (op == 2'd0) nm = "ADD";
    else if (op == 2'd1) nm = "SUB";
    else if (op == 2'd2) begin
      if (f7 == 7'h00) nm = f3_names[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) nm = "SUB";
      else if (f7 == 7'h20 && f3 == 3'd5) nm = "SRA";
      else if (f7 == 7'h01 && f3 == 3'd0) nm = "MUL";
    end else begin
      nm = (f3 == 3'd5 && f7[5]) ? "SRA" : f3_names[f3];
    end
    ill  = (nm == "ILL");
    ctrl = code_of(nm);
    if      (nm == "ADD")  res = a + b;
    else if (nm == "SUB")  res = a - b;
    else if (nm == "AND")  res = a & b;
    else if (nm == "OR")   res = a | b;
    else if (nm == "XOR")  res = a ^ b;
    else if (nm == "SLL")  res = a << sh;
    else if (nm == "SRL")  res = a >> sh;
    else if (nm == "SRA")  res = $unsigned($signed(a) >>> sh);
    else if (nm == "SLT")  res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
    else if (nm == "SLTU") res = (a < b) ? 64'd1 : 64'd0;
    else if (nm == "MUL")  res = a * b;
    else                   res = 64'd0;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] a, input logic [63:0] b);
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
  endtask

  // Issues one operation at a negedge and checks the produced result against the model.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b);
    logic        eill;
    logic [3:0]  ectrl;
    logic [63:0] eres;
    int          cyc;
    logic        ready_bad;
    model(op, f3, f7, a, b, eill, ectrl, eres);
    @(negedge clk);
    drive(op, f3, f7, a, b);
    #1 chk("accept_ready", in_ready, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    if (ectrl == 4'd10 && !eill) begin
      cyc = 1;
      ready_bad = 1'b0;
      while (out_valid !== 1'b1 && cyc < 200) begin
        if (in_ready !== 1'b0) ready_bad = 1'b1;
        @(negedge clk);
        cyc++;
      end
      chk("mul_latency", 64'(cyc), 64'd65);
      chk("mul_stall_ready", ready_bad, 64'd0);
    end
    chk("out_valid", out_valid, 64'd1);
    chk("result", result, eres);
    chk("zero", zero, (eres == 64'd0) ? 64'd1 : 64'd0);
    chk("alu_ctrl", alu_ctrl, ectrl);
    chk("illegal", illegal, eill);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'd0; funct3 = 3'd0; funct7 = 7'd0; op_a = 64'd0; op_b = 64'd0;
    #12;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_zero", zero, 64'd0);
    chk("rst_alu_ctrl", alu_ctrl, 64'd0);
    chk("rst_illegal", illegal, 64'd0);
    chk("rst_in_ready", in_ready, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD via mem/addr path
    run_op(2'b00, 3'd0, 7'd0, 64'd5, 64'd7);
    chk("t1_result", result, 64'd12);
    chk("t1_ctrl", alu_ctrl, 64'b0010);

    // SUB wraps, equal operands set zero
    run_op(2'b10, 3'b000, 7'b0100000, 64'd3, 64'd5);
    chk("t2_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2_ctrl", alu_ctrl, 64'b0110);
    run_op(2'b10, 3'b000, 7'b0100000, 64'd9, 64'd9);
    chk("t2_zero", zero, 64'd1);

    // AND, then back-to-back AND/ADD at one result per cycle
    run_op(2'b10, 3'b111, 7'd0, 64'hF0, 64'h3C);
    chk("t3_result", result, 64'h30);
    @(negedge clk);
    drive(2'b10, 3'b111, 7'd0, 64'hF0, 64'h3C);
    @(negedge clk);
    drive(2'b00, 3'd0, 7'd0, 64'd1, 64'd2);
    chk("b2b_first_valid", out_valid, 64'd1);
    chk("b2b_first_result", result, 64'h30);
    #1 chk("b2b_ready", in_ready, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_valid", out_valid, 64'd1);
    chk("b2b_second_result", result, 64'd3);
    chk("b2b_second_ctrl", alu_ctrl, 64'b0010);

    // MUL latency and result
    run_op(2'b10, 3'b000, 7'b0000001, 64'd6, 64'd7);
    chk("t4_result", result, 64'd42);
    chk("t4_ctrl", alu_ctrl, 64'b1010);

    // Backpressure: result held, no acceptance, then same-cycle accept on release
    @(negedge clk);
    drive(2'b00, 3'd0, 7'd0, 64'd100, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b01, 3'd0, 7'd0, 64'd50, 64'd8);
    #1 chk("bp_ready_low", in_ready, 64'd0);
    chk("bp_result", result, 64'd101);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 64'd1);
      chk("bp_hold_result", result, 64'd101);
      chk("bp_hold_ctrl", alu_ctrl, 64'b0010);
      chk("bp_hold_ready", in_ready, 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 64'd1);
    chk("bp_next_result", result, 64'd42);
    chk("bp_next_ctrl", alu_ctrl, 64'b0110);

    // Illegal encoding
    run_op(2'b10, 3'b100, 7'b0000001, 64'd11, 64'd13);
    chk("t6_illegal", illegal, 64'd1);
    chk("t6_result", result, 64'd0);

    // Reset in the middle of a multiply
    run_op(2'b00, 3'd0, 7'd0, 64'd5, 64'd7);
    @(negedge clk);
    drive(2'b10, 3'b000, 7'b0000001, 64'd123, 64'd456);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 64'd0);
    chk("mrst_result", result, 64'd0);
    chk("mrst_ctrl", alu_ctrl, 64'd0);
    chk("mrst_in_ready", in_ready, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    chk("mrst_no_stale_valid", stale, 64'd0);
    chk("mrst_ready_after", in_ready, 64'd1);

    // Random operations against the model
    for (int n = 0; n < 150; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_f3 = 3'($urandom_range(0, 7));
      sel  = $urandom_range(0, 3);
      r_f7 = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'($urandom);
      r_a  = {$urandom, $urandom};
      r_b  = ($urandom_range(0, 7) == 0) ? r_a : {$urandom, $urandom};
      run_op(r_op, r_f3, r_f7, r_a, r_b);
    end
    for (int n = 0; n < 4; n++) begin
      r_a = {$urandom, $urandom};
      r_b = {$urandom, $urandom};
      run_op(2'b10, 3'b000, 7'b0000001, r_a, r_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
